// File: rtl/overdrive_gain_ctrl.sv
// overdrive_gain_ctrl: clamps accepted gain targets and slews o_gain toward them one step per
// sample tick. Ramping is built only when OVERDRIVE_GAIN_RAMP_EN is defined; otherwise an
// accepted target is applied at once.
module overdrive_gain_ctrl #(
    parameter int unsigned fxp_size           = 16,
    parameter int unsigned bits_per_gain_frac = 4,
    parameter int unsigned step_size          = 1,
    parameter int unsigned gain_reset         = 16,
    parameter int unsigned gain_max           = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_tick,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [fxp_size-1:0] i_cfg_gain,
    output logic [fxp_size-1:0] o_gain,
    output logic                o_busy,
    output logic                o_done
);
    localparam logic [fxp_size-1:0] c_reset = fxp_size'(gain_reset);
    localparam logic [fxp_size-1:0] c_max   = fxp_size'(gain_max);
    localparam logic [fxp_size:0]   c_step  = (fxp_size + 1)'(step_size);

    if (step_size < 1) begin : g_bad_step
        $error("overdrive_gain_ctrl: step_size must be at least 1");
    end

    logic [fxp_size-1:0] r_gain;
    logic                r_done;
    logic [fxp_size-1:0] w_clamped;

    assign w_clamped = (i_cfg_gain > c_max) ? c_max : i_cfg_gain;
    assign o_gain    = r_gain;
    assign o_done    = r_done;

`ifdef OVERDRIVE_GAIN_RAMP_EN
    typedef enum logic {IDLE, RAMP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [fxp_size-1:0] r_target;
    logic                w_accept;
    logic                w_up;
    logic                w_final;
    logic                w_step_unused;
    logic [fxp_size:0]   w_t;
    logic [fxp_size:0]   w_g;
    logic [fxp_size:0]   w_diff;
    logic [fxp_size-1:0] w_step_gain;

    assign w_accept    = i_cfg_valid & (r_state == IDLE);
    assign o_cfg_ready = (r_state == IDLE);
    assign o_busy      = (r_state == RAMP);
    assign w_t         = {1'b0, r_target};
    assign w_g         = {1'b0, r_gain};
    assign w_up        = w_t > w_g;
    assign w_diff      = w_up ? w_t - w_g : w_g - w_t;
    assign w_final     = w_diff <= c_step;
    assign {w_step_unused, w_step_gain} = w_up ? w_g + c_step : w_g - c_step;

    // Next state: enter RAMP on a differing target, leave it on the tick that lands on target.
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_accept && w_clamped != r_gain) w_next = RAMP;
        if (r_state == RAMP && i_tick && w_final) w_next = IDLE;
    end

    // State, target and gain registers; o_done flags the cycle after the gain reaches target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_target <= c_reset;
            r_gain   <= c_reset;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            if (w_accept) r_target <= w_clamped;
            if (r_state == RAMP && i_tick) r_gain <= w_final ? r_target : w_step_gain;
            r_done   <= (w_accept && w_clamped == r_gain) || (r_state == RAMP && i_tick && w_final);
        end
    end
`else
    logic w_tick_unused;

    assign w_tick_unused = i_tick;
    assign o_cfg_ready   = 1'b1;
    assign o_busy        = 1'b0;

    // Without ramping the clamped target is applied directly at the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gain <= c_reset;
            r_done <= 1'b0;
        end else begin
            if (i_cfg_valid) r_gain <= w_clamped;
            r_done <= i_cfg_valid;
        end
    end
`endif
endmodule

// File: tb/tb_overdrive_gain_ctrl.sv
// tb_overdrive_gain_ctrl: directed checks of the gain controller (ramp or direct build).
module tb_overdrive_gain_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        v1 = 1'b0, v3 = 1'b0;
    logic [15:0] g1 = '0, g3 = '0;
    logic        rdy1, rdy3, busy1, busy3, done1, done3;
    logic [15:0] og1, og3;
    int          checks = 0;
    int          failures = 0;

    overdrive_gain_ctrl #(.step_size(1)) u1 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_cfg_valid(v1), .o_cfg_ready(rdy1),
        .i_cfg_gain(g1), .o_gain(og1), .o_busy(busy1), .o_done(done1)
    );

    overdrive_gain_ctrl #(.step_size(3)) u3 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_cfg_valid(v3), .o_cfg_ready(rdy3),
        .i_cfg_gain(g3), .o_gain(og3), .o_busy(busy3), .o_done(done3)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        checks++; if (og1 !== 16'd16) begin failures++; $display("FAIL reset_gain got=%0d exp=16", og1); end
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done1); end
        checks++; if (og3 !== 16'd16) begin failures++; $display("FAIL reset_gain3 got=%0d exp=16", og3); end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

`ifdef OVERDRIVE_GAIN_RAMP_EN
    task automatic test_ramp_up();
        v1 = 1'b1; g1 = 16'd20; v3 = 1'b1; g3 = 16'd20;
        cyc();
        v1 = 1'b0; v3 = 1'b0;
        checks++; if (busy1 !== 1'b1 || rdy1 !== 1'b0) begin failures++; $display("FAIL up_accept got=busy%b/rdy%b exp=busy1/rdy0", busy1, rdy1); end
        checks++; if (og1 !== 16'd16) begin failures++; $display("FAIL up_no_jump got=%0d exp=16", og1); end
        for (int k = 0; k < 4; k++) begin
            repeat (3) cyc();
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            checks++; if (og1 !== 16'(17 + k)) begin failures++; $display("FAIL up_step%0d got=%0d exp=%0d", k, og1, 17 + k); end
            checks++; if (busy1 !== (k < 3)) begin failures++; $display("FAIL up_busy%0d got=%b exp=%b", k, busy1, k < 3); end
            checks++; if (done1 !== (k == 3)) begin failures++; $display("FAIL up_done%0d got=%b exp=%b", k, done1, k == 3); end
        end
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL up_ready_at_done got=%b exp=1", rdy1); end
        cyc();
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL up_done_once got=%b exp=0", done1); end
        checks++; if (og3 !== 16'd20 || busy3 !== 1'b0) begin failures++; $display("FAIL up3_end got=%0d/busy%b exp=20/busy0", og3, busy3); end
    endtask

    task automatic test_ramp_down_step3();
        logic [15:0] exp_g [4];
        exp_g = '{16'd17, 16'd14, 16'd11, 16'd10};
        v3 = 1'b1; g3 = 16'd10;
        cyc();
        v3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            checks++; if (og3 !== exp_g[k]) begin failures++; $display("FAIL down3_step%0d got=%0d exp=%0d", k, og3, exp_g[k]); end
        end
        checks++; if (done3 !== 1'b1 || busy3 !== 1'b0) begin failures++; $display("FAIL down3_done got=done%b/busy%b exp=done1/busy0", done3, busy3); end
        checks++; if (og1 !== 16'd20) begin failures++; $display("FAIL idle_ticks_ignored got=%0d exp=20", og1); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic bad;
        v1 = 1'b1; g1 = 16'hFFFF;
        cyc();
        g1 = 16'd30;
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL hold_off_ready got=%b exp=0", rdy1); end
        n = 0;
        bad = 1'b0;
        tick = 1'b1;
        while (busy1 && n < 400) begin
            cyc();
            n++;
            if (og1 < 16'd20 || og1 > 16'd255) bad = 1'b1;
        end
        tick = 1'b0;
        checks++; if (n !== 235) begin failures++; $display("FAIL clamp_ticks got=%0d exp=235", n); end
        checks++; if (og1 !== 16'd255) begin failures++; $display("FAIL clamp_gain got=%0d exp=255", og1); end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL clamp_range got=%b exp=0", bad); end
        checks++; if (done1 !== 1'b1 || rdy1 !== 1'b1) begin failures++; $display("FAIL clamp_done got=done%b/rdy%b exp=done1/rdy1", done1, rdy1); end
        cyc();
        v1 = 1'b0;
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || og1 !== 16'd255) begin failures++; $display("FAIL held_accept got=busy%b/done%b/%0d exp=busy1/done0/255", busy1, done1, og1); end
        n = 0;
        tick = 1'b1;
        while (busy1 && n < 400) begin
            cyc();
            n++;
        end
        tick = 1'b0;
        checks++; if (n !== 225 || og1 !== 16'd30) begin failures++; $display("FAIL second_ramp got=%0d ticks/%0d exp=225 ticks/30", n, og1); end
        cyc();
    endtask

    task automatic test_equal_and_reset();
        v1 = 1'b1; g1 = 16'd30;
        cyc();
        v1 = 1'b0;
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b1) begin failures++; $display("FAIL equal_target got=busy%b/done%b exp=busy0/done1", busy1, done1); end
        cyc();
        rst = 1'b1;
        #1;
        checks++; if (og1 !== 16'd16) begin failures++; $display("FAIL reset_to16 got=%0d exp=16", og1); end
        cyc();
        rst = 1'b0;
        v1 = 1'b1; g1 = 16'd40;
        cyc();
        v1 = 1'b0;
        repeat (2) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
        checks++; if (og1 !== 16'd18 || busy1 !== 1'b1) begin failures++; $display("FAIL mid_ramp got=%0d/busy%b exp=18/busy1", og1, busy1); end
        #2 rst = 1'b1;
        #1;
        checks++; if (og1 !== 16'd16 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin failures++; $display("FAIL abort got=%0d/busy%b/rdy%b exp=16/busy0/rdy1", og1, busy1, rdy1); end
        cyc();
        rst = 1'b0;
        tick = 1'b1;
        repeat (3) begin
            cyc();
            checks++; if (done1 !== 1'b0 || og1 !== 16'd16) begin failures++; $display("FAIL abort_quiet got=done%b/%0d exp=done0/16", done1, og1); end
        end
        tick = 1'b0;
    endtask
`else
    task automatic test_direct();
        v1 = 1'b1; g1 = 16'd200;
        cyc();
        v1 = 1'b0;
        checks++; if (og1 !== 16'd200) begin failures++; $display("FAIL direct_gain got=%0d exp=200", og1); end
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin failures++; $display("FAIL direct_flags got=done%b/busy%b/rdy%b exp=1/0/1", done1, busy1, rdy1); end
        cyc();
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL direct_done_once got=%b exp=0", done1); end
        tick = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        checks++; if (og1 !== 16'd200 || done1 !== 1'b0) begin failures++; $display("FAIL tick_ignored got=%0d/done%b exp=200/done0", og1, done1); end
    endtask

    task automatic test_back_to_back();
        v1 = 1'b1; g1 = 16'hFFFF;
        cyc();
        checks++; if (og1 !== 16'd255) begin failures++; $display("FAIL clamp_gain got=%0d exp=255", og1); end
        g1 = 16'd255;
        cyc();
        checks++; if (og1 !== 16'd255 || done1 !== 1'b1) begin failures++; $display("FAIL equal_target got=%0d/done%b exp=255/done1", og1, done1); end
        g1 = 16'd10;
        cyc();
        g1 = 16'd20;
        checks++; if (og1 !== 16'd10) begin failures++; $display("FAIL b2b_first got=%0d exp=10", og1); end
        cyc();
        v1 = 1'b0;
        checks++; if (og1 !== 16'd20 || done1 !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0d/done%b exp=20/done1", og1, done1); end
        v3 = 1'b1; g3 = 16'd256;
        cyc();
        v3 = 1'b0;
        checks++; if (og3 !== 16'd255) begin failures++; $display("FAIL clamp_256 got=%0d exp=255", og3); end
    endtask

    task automatic test_equal_and_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (og1 !== 16'd16 || done1 !== 1'b0) begin failures++; $display("FAIL reset_mid got=%0d/done%b exp=16/done0", og1, done1); end
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (og1 !== 16'd16 || done1 !== 1'b0) begin failures++; $display("FAIL reset_quiet got=%0d/done%b exp=16/done0", og1, done1); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef OVERDRIVE_GAIN_RAMP_EN
        test_ramp_up();
        test_ramp_down_step3();
`else
        test_direct();
`endif
        test_back_to_back();
        test_equal_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
